regfile_wb_arbiter: RTL and testbench

- Arbitrates the register-file write port among three writeback sources: req0 ALU result, req1 memory load, req2 immediate/move.
- Issues at most one write per cycle, as a one-hot load-enable vector plus a data bus.
- These drive the L and D inputs of the NREG 16-bit load-enabled registers in the register bank.
- Round-robin policy bounds every requester's wait to NREQ grant cycles. A stall input freezes arbitration.

---
 rtl/regfile_wb_arbiter.sv | 92 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the register-file write port: picks one of three
// writeback sources per cycle and drives a one-hot load enable plus write data.
module regfile_wb_arbiter #(
  parameter int WIDTH  = 16,
  parameter int NREG   = 8,
  parameter int ADDR_W = 3,
  parameter int NREQ   = 3
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              stall,
  input  logic [2:0]        req,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [WIDTH-1:0]  data0,
  input  logic [WIDTH-1:0]  data1,
  input  logic [WIDTH-1:0]  data2,
  output logic [2:0]        gnt,
  output logic [NREG-1:0]   L_out,
  output logic [WIDTH-1:0]  D_out,
  output logic              wr_err,
  output logic              busy,
  output logic [1:0]        rr_ptr
);

  // Handshake: req[i] is a level request; the requester holds req/addr/data
  // until it sees gnt[i]=1, and must drop or renew them during that cycle.

  localparam logic [ADDR_W:0]  NREG_V = (ADDR_W + 1)'(NREG);
  localparam logic [NREG-1:0]  ONE_L  = {{(NREG-1){1'b0}}, 1'b1};

  logic [1:0]        idx0, idx1, idx2;
  logic              win;
  logic [1:0]        win_idx;
  logic [ADDR_W-1:0] sel_addr;
  logic [WIDTH-1:0]  sel_data;
  logic              addr_ok;

  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  assign busy = |req;

  // Search order starts at rr_ptr and walks upward modulo 3.
  always_comb begin
    idx0    = rr_ptr;
    idx1    = inc3(idx0);
    idx2    = inc3(idx1);
    win     = 1'b1;
    win_idx = idx0;
    if (req[idx0])      win_idx = idx0;
    else if (req[idx1]) win_idx = idx1;
    else if (req[idx2]) win_idx = idx2;
    else                win = 1'b0;
  end

  always_comb begin
    sel_addr = addr0;
    sel_data = data0;
    case (win_idx)
      2'd1:    begin sel_addr = addr1; sel_data = data1; end
      2'd2:    begin sel_addr = addr2; sel_data = data2; end
      default: begin sel_addr = addr0; sel_data = data0; end
    endcase
    addr_ok = ({1'b0, sel_addr} < NREG_V);
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      gnt    <= '0;
      L_out  <= '0;
      D_out  <= '0;
      wr_err <= 1'b0;
      rr_ptr <= 2'd0;
    end else if (stall || !win) begin
      gnt    <= '0;
      L_out  <= '0;
      wr_err <= 1'b0;
    end else begin
      gnt    <= 3'b001 << win_idx;
      D_out  <= sel_data;
      L_out  <= addr_ok ? (ONE_L << sel_addr) : '0;
      wr_err <= !addr_ok;
      // Pointer advances even on an out-of-range grant so the bad writer
      // cannot monopolise the port.
      rr_ptr <= inc3(win_idx);
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: one 8-register and one 6-register
// instance share stimulus so in-range and out-of-range writes are both covered.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset, stall;
  logic [2:0]  req;
  logic [2:0]  addr0, addr1, addr2;
  logic [15:0] data0, data1, data2;

  logic [2:0]  gnt8, gnt6;
  logic [7:0]  l8;
  logic [5:0]  l6;
  logic [15:0] d8, d6;
  logic        err8, err6, busy8, busy6;
  logic [1:0]  ptr8, ptr6;

  int total = 0;
  int bad   = 0;

  // {gnt, l8, l6, d, err8, err6, ptr}
  localparam int EW = 37;
  logic [EW-1:0] exp_q[$];

  int          m_ptr = 0;
  logic [15:0] m_d   = '0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.WIDTH(16), .NREG(8), .ADDR_W(3), .NREQ(3)) u_dut8 (
    .CLK(clk), .reset(reset), .stall(stall), .req(req),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .data0(data0), .data1(data1), .data2(data2),
    .gnt(gnt8), .L_out(l8), .D_out(d8), .wr_err(err8), .busy(busy8), .rr_ptr(ptr8)
  );

  regfile_wb_arbiter #(.WIDTH(16), .NREG(6), .ADDR_W(3), .NREQ(3)) u_dut6 (
    .CLK(clk), .reset(reset), .stall(stall), .req(req),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .data0(data0), .data1(data1), .data2(data2),
    .gnt(gnt6), .L_out(l6), .D_out(d6), .wr_err(err6), .busy(busy6), .rr_ptr(ptr6)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle, predict the registered outputs, then compare after the edge.
  task automatic step(input logic rst, input logic stl, input logic [2:0] rq);
    logic [2:0]  e_g;
    logic [7:0]  e_l8;
    logic [5:0]  e_l6;
    logic        e_e8, e_e6, found;
    logic [2:0]  a;
    logic [15:0] dv;
    logic [EW-1:0] e;
    int i;
    @(negedge clk);
    reset = rst; stall = stl; req = rq;
    #1;
    check("busy8", {31'd0, busy8}, {31'd0, |rq});
    check("busy6", {31'd0, busy6}, {31'd0, |rq});
    e_g = '0; e_l8 = '0; e_l6 = '0; e_e8 = 1'b0; e_e6 = 1'b0; found = 1'b0;
    if (rst) begin
      m_ptr = 0; m_d = '0;
    end else if (!stl && rq != 3'b000) begin
      for (int k = 0; k < 3; k++) begin
        i = (m_ptr + k) % 3;
        if (!found && rq[i]) begin
          found = 1'b1;
          a  = (i == 0) ? addr0 : (i == 1) ? addr1 : addr2;
          dv = (i == 0) ? data0 : (i == 1) ? data1 : data2;
          e_g  = 3'(1 << i);
          m_d  = dv;
          e_l8 = 8'(1 << a);
          if (a < 6) e_l6 = 6'(1 << a);
          else       e_e6 = 1'b1;
          m_ptr = (i + 1) % 3;
        end
      end
    end
    exp_q.push_back({e_g, e_l8, e_l6, m_d, e_e8, e_e6, 2'(m_ptr)});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("gnt8",  {29'd0, gnt8}, {29'd0, e[36:34]});
    check("gnt6",  {29'd0, gnt6}, {29'd0, e[36:34]});
    check("l8",    {24'd0, l8},   {24'd0, e[33:26]});
    check("l6",    {26'd0, l6},   {26'd0, e[25:20]});
    check("d8",    {16'd0, d8},   {16'd0, e[19:4]});
    check("d6",    {16'd0, d6},   {16'd0, e[19:4]});
    check("err8",  {31'd0, err8}, {31'd0, e[3]});
    check("err6",  {31'd0, err6}, {31'd0, e[2]});
    check("ptr8",  {30'd0, ptr8}, {30'd0, e[1:0]});
    check("ptr6",  {30'd0, ptr6}, {30'd0, e[1:0]});
    check("l8_onehot", {31'd0, $onehot0(l8)}, 32'd1);
    check("gnt_onehot", {31'd0, $onehot0(gnt8)}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; req = '0;
    addr0 = '0; addr1 = '0; addr2 = '0;
    data0 = '0; data1 = '0; data2 = '0;

    step(1'b1, 1'b0, 3'b000);
    step(1'b1, 1'b0, 3'b000);

    // All three requesting: 0,1,2 in order.
    addr0 = 3'd1; addr1 = 3'd2; addr2 = 3'd3;
    data0 = 16'h00A1; data1 = 16'h00B2; data2 = 16'h00C3;
    repeat (3) step(1'b0, 1'b0, 3'b111);

    // Grant 0 moves the pointer to 1; then 2 wins and the pointer wraps to 0.
    step(1'b0, 1'b0, 3'b001);
    step(1'b0, 1'b0, 3'b101);
    step(1'b0, 1'b0, 3'b001);
    step(1'b0, 1'b0, 3'b000);

    // Stall holds off a pending request, then releases it.
    addr1 = 3'd5; data1 = 16'hBEEF;
    repeat (4) step(1'b0, 1'b1, 3'b010);
    step(1'b0, 1'b0, 3'b010);
    step(1'b0, 1'b1, 3'b010);
    step(1'b0, 1'b0, 3'b000);

    // Out-of-range destination on the 6-register bank.
    addr0 = 3'd7; data0 = 16'h1234;
    step(1'b0, 1'b0, 3'b001);
    addr0 = 3'd6; data0 = 16'h5678;
    step(1'b0, 1'b0, 3'b001);
    step(1'b0, 1'b0, 3'b000);

    // Reset wins over a grant being formed.
    step(1'b1, 1'b0, 3'b010);
    step(1'b0, 1'b0, 3'b000);

    // Single requester granted every cycle.
    addr2 = 3'd4;
    for (int n = 1; n <= 4; n++) begin
      data2 = 16'(n);
      step(1'b0, 1'b0, 3'b100);
    end
    step(1'b0, 1'b0, 3'b000);

    // Random traffic.
    for (int n = 0; n < 60; n++) begin
      addr0 = 3'($urandom_range(0, 7));
      addr1 = 3'($urandom_range(0, 7));
      addr2 = 3'($urandom_range(0, 7));
      data0 = 16'($urandom_range(0, 65535));
      data1 = 16'($urandom_range(0, 65535));
      data2 = 16'($urandom_range(0, 65535));
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 4) == 0),
           3'($urandom_range(0, 7)));
    end

    check("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
